spin_ctrl: RTL and testbench

SPIN_CTRL -- requirements
Module: spin_ctrl

---
 rtl/spin_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_spin_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_ctrl.sv
// ---------------------------------------------------------------------------
// spin_ctrl -- three-reel slot machine controller
//
// Purpose:
//   Keeps a credit balance, accepts a spin when enough credits are present,
//   seeds three external random generators from a free-running counter,
//   lets each reel follow its generator until it locks in turn, evaluates
//   the locked symbols into a payout and credits the win back.
//
// Parameters:
//   SPIN_CYC  cycles each reel spins before it locks (2..255)
//   BET       credits deducted per accepted spin     (1..255)
//
// Optional build macro:
//   JACKPOT_EN  when defined, three reels all showing 4'd7 pay 8'd50 instead
//               of the ordinary triple payout.
//
// Ports:
//   clk                  single clock, rising edge
//   rst                  synchronous active-high reset
//   coin                 adds one credit for every cycle it is high
//   start                spin request, level sampled in IDLE only
//   rnum1..rnum3  [3:0]  live values from the three random generators
//   seed1..seed3  [5:0]  seeds driven to the three generators
//   reel1..reel3  [3:0]  displayed reel symbols
//   lock          [2:0]  bit i high once reel i+1 is locked
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse when a spin completes
//   payout        [7:0]  win amount of the last spin
//   credits       [7:0]  current credit balance
// ---------------------------------------------------------------------------
module spin_ctrl #(
    parameter int SPIN_CYC = 8,
    parameter int BET      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin,
    input  logic       start,
    input  logic [3:0] rnum1,
    input  logic [3:0] rnum2,
    input  logic [3:0] rnum3,
    output logic [5:0] seed1,
    output logic [5:0] seed2,
    output logic [5:0] seed3,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [3:0] reel3,
    output logic [2:0] lock,
    output logic       busy,
    output logic       done,
    output logic [7:0] payout,
    output logic [7:0] credits
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN1 = 3'd1,
        ST_SPIN2 = 3'd2,
        ST_SPIN3 = 3'd3,
        ST_EVAL  = 3'd4,
        ST_PAY   = 3'd5
    } state_t;

    // Spin counter compares against the last cycle index of a reel's spin.
    localparam logic [7:0] SPIN_LAST  = 8'(SPIN_CYC - 1);
    localparam logic [7:0] BET_W      = 8'(BET);
    localparam logic [7:0] CRED_RESET = 8'd10;

    // Win table; the first matching rule wins.
`ifdef JACKPOT_EN
    function automatic logic [7:0] calc_payout(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic [3:0] c);
        logic [7:0] pay;
        if ((a == 4'd7) && (b == 4'd7) && (c == 4'd7)) begin
            pay = 8'd50;
        end else if ((a == b) && (b == c)) begin
            pay = 8'd10;
        end else if ((a == b) || (b == c)) begin
            pay = 8'd2;
        end else begin
            pay = 8'd0;
        end
        return pay;
    endfunction
`else
    function automatic logic [7:0] calc_payout(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic [3:0] c);
        logic [7:0] pay;
        if ((a == b) && (b == c)) begin
            pay = 8'd10;
        end else if ((a == b) || (b == c)) begin
            pay = 8'd2;
        end else begin
            pay = 8'd0;
        end
        return pay;
    endfunction
`endif

    // Credit arithmetic is done 10 bits wide: 255 + coin + 255 still fits,
    // and a deduction only happens when credits >= BET, so it never wraps.
    function automatic logic [7:0] sat_credits(input logic [9:0] sum);
        logic [7:0] res;
        if (sum > 10'd255) begin
            res = 8'd255;
        end else begin
            res = sum[7:0];
        end
        return res;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_sctr;
    logic [7:0]  r_spin_cnt;
    logic [5:0]  r_seed1;
    logic [5:0]  r_seed2;
    logic [5:0]  r_seed3;
    logic [3:0]  r_reel1;
    logic [3:0]  r_reel2;
    logic [3:0]  r_reel3;
    logic [2:0]  r_lock;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_payout;
    logic [7:0]  r_credits;

    logic        w_accept;
    logic        w_lock1;
    logic        w_lock2;
    logic        w_lock3;
    logic        w_eval;
    logic        w_pay;
    logic        w_spinning;
    logic        w_follow2;
    logic        w_follow3;
    logic        w_spin_end;
    logic [9:0]  w_cred_sum;
    logic [7:0]  w_cred_nxt;

    assign w_spin_end = (r_spin_cnt == SPIN_LAST);

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_lock1     = 1'b0;
        w_lock2     = 1'b0;
        w_lock3     = 1'b0;
        w_eval      = 1'b0;
        w_pay       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (r_credits >= BET_W)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SPIN1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SPIN1: begin
                if (w_spin_end) begin
                    w_lock1     = 1'b1;
                    w_state_nxt = ST_SPIN2;
                end else begin
                    w_state_nxt = ST_SPIN1;
                end
            end
            ST_SPIN2: begin
                if (w_spin_end) begin
                    w_lock2     = 1'b1;
                    w_state_nxt = ST_SPIN3;
                end else begin
                    w_state_nxt = ST_SPIN2;
                end
            end
            ST_SPIN3: begin
                if (w_spin_end) begin
                    w_lock3     = 1'b1;
                    w_state_nxt = ST_EVAL;
                end else begin
                    w_state_nxt = ST_SPIN3;
                end
            end
            ST_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = ST_PAY;
            end
            ST_PAY: begin
                w_pay       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Which reels are still unlocked and therefore tracking their generator.
    always_comb begin
        w_spinning = 1'b0;
        w_follow2  = 1'b0;
        w_follow3  = 1'b0;
        case (r_state)
            ST_SPIN1: begin
                w_spinning = 1'b1;
                w_follow2  = 1'b1;
                w_follow3  = 1'b1;
            end
            ST_SPIN2: begin
                w_spinning = 1'b1;
                w_follow2  = 1'b1;
                w_follow3  = 1'b1;
            end
            ST_SPIN3: begin
                w_spinning = 1'b1;
                w_follow3  = 1'b1;
            end
            default: begin
                w_spinning = 1'b0;
            end
        endcase
    end

    // Coin, bet and win land in one saturating update when they coincide.
    always_comb begin
        w_cred_sum = {2'b00, r_credits} + {9'd0, coin};
        if (w_accept) begin
            w_cred_sum = w_cred_sum - {2'b00, BET_W};
        end else begin
            w_cred_sum = w_cred_sum;
        end
        if (w_pay) begin
            w_cred_sum = w_cred_sum + {2'b00, r_payout};
        end else begin
            w_cred_sum = w_cred_sum;
        end
        w_cred_nxt = sat_credits(w_cred_sum);
    end

    // State register; busy is registered alongside so it tracks the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Free-running seed source counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sctr <= 6'd0;
        end else begin
            r_sctr <= r_sctr + 6'd1;
        end
    end

    // Per-reel spin timer, restarted on acceptance and at every lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spin_cnt <= 8'd0;
        end else if (w_accept || w_lock1 || w_lock2 || w_lock3) begin
            r_spin_cnt <= 8'd0;
        end else if (w_spinning) begin
            r_spin_cnt <= r_spin_cnt + 8'd1;
        end
    end

    // Seeds are captured only when a spin is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed1 <= 6'd0;
            r_seed2 <= 6'd0;
            r_seed3 <= 6'd0;
        end else if (w_accept) begin
            r_seed1 <= r_sctr;
            r_seed2 <= r_sctr ^ 6'h15;
            r_seed3 <= r_sctr + 6'd23;
        end
    end

    // Unlocked reels sample their generator; the locking edge takes the
    // final sample, after which the reel holds until the next spin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reel1 <= 4'd0;
            r_reel2 <= 4'd0;
            r_reel3 <= 4'd0;
        end else begin
            if (r_state == ST_SPIN1) begin
                r_reel1 <= rnum1;
            end
            if (w_follow2) begin
                r_reel2 <= rnum2;
            end
            if (w_follow3) begin
                r_reel3 <= rnum3;
            end
        end
    end

    // Lock flags: cleared by a new spin, set one by one as reels stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 3'b000;
        end else if (w_accept) begin
            r_lock <= 3'b000;
        end else begin
            if (w_lock1) begin
                r_lock[0] <= 1'b1;
            end
            if (w_lock2) begin
                r_lock[1] <= 1'b1;
            end
            if (w_lock3) begin
                r_lock[2] <= 1'b1;
            end
        end
    end

    // Payout is cleared by a new spin and held after evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_payout <= 8'd0;
        end else if (w_accept) begin
            r_payout <= 8'd0;
        end else if (w_eval) begin
            r_payout <= calc_payout(r_reel1, r_reel2, r_reel3);
        end
    end

    // Credit balance and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CRED_RESET;
            r_done    <= 1'b0;
        end else begin
            r_credits <= w_cred_nxt;
            r_done    <= w_pay;
        end
    end

    assign seed1   = r_seed1;
    assign seed2   = r_seed2;
    assign seed3   = r_seed3;
    assign reel1   = r_reel1;
    assign reel2   = r_reel2;
    assign reel3   = r_reel3;
    assign lock    = r_lock;
    assign busy    = r_busy;
    assign done    = r_done;
    assign payout  = r_payout;
    assign credits = r_credits;

endmodule

// File: tb/tb_spin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spin_ctrl -- directed self-checking bench for spin_ctrl
// Built with SPIN_CYC=4, BET=1. Honours JACKPOT_EN for the triple-7 payout.
// ---------------------------------------------------------------------------
module tb_spin_ctrl;

    logic       clk;
    logic       rst;
    logic       coin;
    logic       start;
    logic [3:0] rnum1;
    logic [3:0] rnum2;
    logic [3:0] rnum3;
    logic [5:0] seed1;
    logic [5:0] seed2;
    logic [5:0] seed3;
    logic [3:0] reel1;
    logic [3:0] reel2;
    logic [3:0] reel3;
    logic [2:0] lock;
    logic       busy;
    logic       done;
    logic [7:0] payout;
    logic [7:0] credits;

    int n_vec;
    int n_miss;
    int exp_cred;

`ifdef JACKPOT_EN
    localparam int JP_PAY = 50;
`else
    localparam int JP_PAY = 10;
`endif

    spin_ctrl #(.SPIN_CYC(4), .BET(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .coin    (coin),
        .start   (start),
        .rnum1   (rnum1),
        .rnum2   (rnum2),
        .rnum3   (rnum3),
        .seed1   (seed1),
        .seed2   (seed2),
        .seed3   (seed3),
        .reel1   (reel1),
        .reel2   (reel2),
        .reel3   (reel3),
        .lock    (lock),
        .busy    (busy),
        .done    (done),
        .payout  (payout),
        .credits (credits)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete spin with constant generator values; exp_cred is the
    // bench's running balance.
    task automatic do_spin(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input int exp_pay);
        int n;
        rnum1 = a;
        rnum2 = b;
        rnum3 = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cred = exp_cred - 1;
        chk({tag, "_acc_cred"}, credits, exp_cred);
        chk({tag, "_acc_busy"}, busy, 1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done_lat"}, n, 14);
        exp_cred = exp_cred + exp_pay;
        if (exp_cred > 255) exp_cred = 255;
        chk({tag, "_payout"}, payout, exp_pay);
        chk({tag, "_cred"}, credits, exp_cred);
        chk({tag, "_reels"}, {reel1, reel2, reel3}, {a, b, c});
        chk({tag, "_lock"}, lock, 3'b111);
        tick();
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int dcount;
        int n;
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        coin   = 1'b0;
        start  = 1'b0;
        rnum1  = 4'd0;
        rnum2  = 4'd0;
        rnum3  = 4'd0;

        // Reset state.
        tick();
        rst = 1'b0;
        chk("rst_cred", credits, 10);
        chk("rst_busy", busy, 0);
        chk("rst_lock", lock, 0);
        chk("rst_done", done, 0);
        chk("rst_payout", payout, 0);
        chk("rst_seeds", {seed1, seed2, seed3}, 18'd0);
        chk("rst_reels", {reel1, reel2, reel3}, 12'd0);
        exp_cred = 10;

        // Three idle cycles: counter reaches 3, nothing else moves.
        for (int i = 0; i < 3; i++) tick();
        chk("idle_cred", credits, 10);
        chk("idle_busy", busy, 0);
        chk("idle_lock", lock, 0);

        // Start at edge 0 with all generators at 5; seeds come from counter=3.
        rnum1 = 4'd5;
        rnum2 = 4'd5;
        rnum3 = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_cred0", credits, 9);
        chk("t1_busy0", busy, 1);
        chk("t1_seed1", seed1, 3);
        chk("t1_seed2", seed2, 6'h16);
        chk("t1_seed3", seed3, 26);
        for (int e = 1; e <= 14; e++) begin
            tick();
            chk($sformatf("t1_lock_e%0d", e), lock,
                {(e >= 12) ? 1'b1 : 1'b0, (e >= 8) ? 1'b1 : 1'b0, (e >= 4) ? 1'b1 : 1'b0});
            chk($sformatf("t1_done_e%0d", e), done, (e == 14) ? 1 : 0);
            chk($sformatf("t1_busy_e%0d", e), busy, (e < 14) ? 1 : 0);
            chk($sformatf("t1_pay_e%0d", e), payout, (e >= 13) ? 10 : 0);
            chk($sformatf("t1_cred_e%0d", e), credits, (e == 14) ? 19 : 9);
            if (e == 1) chk("t1_reel1_follow", reel1, 5);
        end
        exp_cred = 19;
        tick();
        chk("t1_done_off", done, 0);

        // Pair, loss, right-hand pair, triple 7s.
        do_spin("pair12", 4'd3, 4'd3, 4'd9, 2);
        do_spin("loss", 4'd1, 4'd2, 4'd4, 0);
        do_spin("pair23", 4'd3, 4'd4, 4'd4, 2);
        do_spin("sevens", 4'd7, 4'd7, 4'd7, JP_PAY);

        // Feed coins up to 250, then a triple win saturates at 255.
        coin = 1'b1;
        while (exp_cred < 250) begin
            tick();
            exp_cred++;
        end
        coin = 1'b0;
        chk("coin_to_250", credits, 250);
        do_spin("sat", 4'd5, 4'd5, 4'd5, 10);

        // Reset mid-spin (in SPIN2) together with coin and start.
        rnum1 = 4'd1;
        rnum2 = 4'd2;
        rnum3 = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_acc_cred", credits, 254);
        for (int e = 1; e <= 5; e++) tick();
        chk("mid_lock_spin2", lock, 3'b001);
        rst   = 1'b1;
        coin  = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        coin  = 1'b0;
        start = 1'b0;
        chk("mid_rst_cred", credits, 10);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_lock", lock, 0);
        chk("mid_rst_payout", payout, 0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dcount++;
        end
        chk("mid_no_done", dcount, 0);
        chk("mid_idle_busy", busy, 0);
        exp_cred = 10;

        // Start held through a whole spin: ignored while busy, then a fresh
        // spin right after done. Coin lands on the second spin's pay edge.
        rnum1 = 4'd1;
        rnum2 = 4'd2;
        rnum3 = 4'd4;
        start = 1'b1;
        tick();
        chk("hold_acc_cred", credits, 9);
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 10) chk("hold_spin3_cred", credits, 9);
            if (e == 10) chk("hold_spin3_lock", lock, 3'b011);
        end
        chk("hold_done", done, 1);
        chk("hold_cred", credits, 9);
        chk("hold_busy_idle", busy, 0);
        rnum1 = 4'd5;
        rnum2 = 4'd5;
        rnum3 = 4'd9;
        tick();
        start = 1'b0;
        chk("again_cred", credits, 8);
        chk("again_busy", busy, 1);
        chk("again_payout_clr", payout, 0);
        for (int e = 16; e <= 29; e++) begin
            if (e == 29) coin = 1'b1;
            tick();
        end
        coin = 1'b0;
        chk("again_done", done, 1);
        chk("again_payout", payout, 2);
        chk("again_cred_net", credits, 11);
        exp_cred = 11;

        // Drain to zero with losing spins.
        for (int i = 0; i < 11; i++) do_spin("drain", 4'd1, 4'd2, 4'd4, 0);
        chk("drain_zero", credits, 0);

        // No credits: start ignored.
        start = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0;
        chk("broke_busy", busy, 0);
        chk("broke_cred", credits, 0);
        chk("broke_done", done, 0);

        // One coin, then a spin is accepted down to zero.
        coin = 1'b1;
        tick();
        coin = 1'b0;
        chk("one_coin", credits, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("coin_spin_cred", credits, 0);
        chk("coin_spin_busy", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("coin_spin_lat", n, 14);
        chk("coin_spin_end", credits, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
